// File: rtl/csi_packet_sequencer.sv
// CSI-2 packet sequencer: checks header ECC, decodes short/long packets and
// streams long-packet payload words with byte enables toward the pixel path.
module csi_packet_sequencer #(
    parameter int MAX_WC    = 4096,
    parameter int LINE_BITS = 16
) (
    input  logic                 mipi_clk,
    input  logic                 reset,
    input  logic                 stop,
    input  logic [31:0]          word_in,
    input  logic                 word_valid,
    output logic [7:0]           data_id,
    output logic [15:0]          word_count,
    output logic [31:0]          pix_data,
    output logic [3:0]           pix_be,
    output logic                 pix_valid,
    output logic                 frame_start,
    output logic                 frame_end,
    output logic                 line_start,
    output logic                 line_end,
    output logic                 frame_active,
    output logic [LINE_BITS-1:0] line_count,
    output logic                 ecc_err,
    output logic                 pkt_abort,
    output logic                 stop_req
);

    typedef enum logic [2:0] {IDLE, HEADER, PAYLOAD, FOOTER, WAIT_STOP} state_t;

    localparam logic [16:0] MaxWc = 17'(MAX_WC);

    state_t                 state_q, state_d;
    logic [15:0]            rem_q, rem_d;
    logic [7:0]             data_id_q, data_id_d;
    logic [15:0]            word_count_q, word_count_d;
    logic [31:0]            pix_data_q, pix_data_d;
    logic [3:0]             pix_be_q, pix_be_d;
    logic                   pix_valid_q, pix_valid_d;
    logic                   frame_start_q, frame_start_d;
    logic                   frame_end_q, frame_end_d;
    logic                   line_start_q, line_start_d;
    logic                   line_end_q, line_end_d;
    logic                   frame_active_q, frame_active_d;
    logic [LINE_BITS-1:0]   line_count_q, line_count_d;
    logic                   ecc_err_q, ecc_err_d;
    logic                   pkt_abort_q, pkt_abort_d;
    logic                   stop_req_q, stop_req_d;
    logic                   end_pkt;
    logic [5:0]             hdr_dt;
    logic [15:0]            hdr_wc;
    logic                   hdr_ecc_ok;

    // CSI-2 header Hamming code: six parity bits over DI and WC.
    function automatic logic [5:0] calc_ecc(input logic [23:0] d);
        logic [5:0] p;
        p[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
        p[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
        p[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]^d[20]^d[21]^d[22];
        p[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]^d[20]^d[21]^d[23];
        p[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]^d[20]^d[22]^d[23];
        p[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]^d[19]^d[21]^d[22]^d[23];
        return p;
    endfunction

    assign hdr_dt     = word_in[5:0];
    assign hdr_wc     = word_in[23:8];
    assign hdr_ecc_ok = (word_in[31:24] == {2'b00, calc_ecc(word_in[23:0])});

    always_comb begin
        state_d        = state_q;
        rem_d          = rem_q;
        data_id_d      = data_id_q;
        word_count_d   = word_count_q;
        pix_data_d     = pix_data_q;
        pix_be_d       = pix_be_q;
        pix_valid_d    = 1'b0;
        frame_start_d  = 1'b0;
        frame_end_d    = 1'b0;
        line_start_d   = 1'b0;
        line_end_d     = 1'b0;
        frame_active_d = frame_active_q;
        line_count_d   = line_count_q;
        ecc_err_d      = 1'b0;
        pkt_abort_d    = 1'b0;
        end_pkt        = 1'b0;

        case (state_q)
            IDLE: begin
                if (!stop) state_d = HEADER;
            end
            HEADER: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (word_valid) begin
                    state_d = WAIT_STOP;
                    if (!hdr_ecc_ok) begin
                        ecc_err_d = 1'b1;
                    end else begin
                        data_id_d    = word_in[7:0];
                        word_count_d = hdr_wc;
                        if (hdr_dt < 6'h10) begin
                            case (hdr_dt)
                                6'h00: begin
                                    frame_start_d  = 1'b1;
                                    frame_active_d = 1'b1;
                                    line_count_d   = '0;
                                end
                                6'h01: begin
                                    frame_end_d    = 1'b1;
                                    frame_active_d = 1'b0;
                                end
                                6'h02: line_start_d = 1'b1;
                                6'h03: line_end_d   = 1'b1;
                                default: ;
                            endcase
                        end else if (hdr_wc == 16'd0 || {1'b0, hdr_wc} > MaxWc) begin
                            ecc_err_d = 1'b1;
                        end else begin
                            rem_d   = hdr_wc;
                            state_d = PAYLOAD;
                        end
                    end
                end
            end
            PAYLOAD: begin
                if (stop) begin
                    state_d     = IDLE;
                    pkt_abort_d = 1'b1;
                end else if (word_valid) begin
                    pix_data_d  = word_in;
                    pix_valid_d = 1'b1;
                    if (rem_q >= 16'd4) begin
                        pix_be_d = 4'b1111;
                        rem_d    = rem_q - 16'd4;
                    end else begin
                        pix_be_d = (4'b0001 << rem_q[1:0]) - 4'b0001;
                        rem_d    = 16'd0;
                    end
                    // CRC spills into an extra word when the payload ends on byte lane 3 or 4.
                    if (rem_d == 16'd0) begin
                        if (word_count_q[1:0] == 2'd0 || word_count_q[1:0] == 2'd3) begin
                            state_d = FOOTER;
                        end else begin
                            state_d = WAIT_STOP;
                            end_pkt = 1'b1;
                        end
                    end
                end
            end
            FOOTER: begin
                if (stop) begin
                    state_d     = IDLE;
                    pkt_abort_d = 1'b1;
                end else if (word_valid) begin
                    state_d = WAIT_STOP;
                    end_pkt = 1'b1;
                end
            end
            WAIT_STOP: begin
                if (stop) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (end_pkt && frame_active_q && line_count_q != '1)
            line_count_d = line_count_q + LINE_BITS'(1);

        stop_req_d = (state_d == WAIT_STOP);
    end

    always_ff @(posedge mipi_clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            rem_q          <= '0;
            data_id_q      <= '0;
            word_count_q   <= '0;
            pix_data_q     <= '0;
            pix_be_q       <= '0;
            pix_valid_q    <= 1'b0;
            frame_start_q  <= 1'b0;
            frame_end_q    <= 1'b0;
            line_start_q   <= 1'b0;
            line_end_q     <= 1'b0;
            frame_active_q <= 1'b0;
            line_count_q   <= '0;
            ecc_err_q      <= 1'b0;
            pkt_abort_q    <= 1'b0;
            stop_req_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            rem_q          <= rem_d;
            data_id_q      <= data_id_d;
            word_count_q   <= word_count_d;
            pix_data_q     <= pix_data_d;
            pix_be_q       <= pix_be_d;
            pix_valid_q    <= pix_valid_d;
            frame_start_q  <= frame_start_d;
            frame_end_q    <= frame_end_d;
            line_start_q   <= line_start_d;
            line_end_q     <= line_end_d;
            frame_active_q <= frame_active_d;
            line_count_q   <= line_count_d;
            ecc_err_q      <= ecc_err_d;
            pkt_abort_q    <= pkt_abort_d;
            stop_req_q     <= stop_req_d;
        end
    end

    assign data_id      = data_id_q;
    assign word_count   = word_count_q;
    assign pix_data     = pix_data_q;
    assign pix_be       = pix_be_q;
    assign pix_valid    = pix_valid_q;
    assign frame_start  = frame_start_q;
    assign frame_end    = frame_end_q;
    assign line_start   = line_start_q;
    assign line_end     = line_end_q;
    assign frame_active = frame_active_q;
    assign line_count   = line_count_q;
    assign ecc_err      = ecc_err_q;
    assign pkt_abort    = pkt_abort_q;
    assign stop_req     = stop_req_q;

endmodule

// File: tb/tb_csi_packet_sequencer.sv
// Directed bench for csi_packet_sequencer; header ECC bytes are hand-computed
// from the CSI-2 Hamming table.
module tb_csi_packet_sequencer;

    logic        mipi_clk = 1'b0;
    logic        reset    = 1'b0;
    logic        stop     = 1'b1;
    logic [31:0] word_in  = '0;
    logic        word_valid = 1'b0;
    logic [7:0]  data_id;
    logic [15:0] word_count;
    logic [31:0] pix_data;
    logic [3:0]  pix_be;
    logic        pix_valid;
    logic        frame_start, frame_end, line_start, line_end;
    logic        frame_active;
    logic [15:0] line_count;
    logic        ecc_err, pkt_abort, stop_req;

    int checks = 0;
    int passed = 0;

    csi_packet_sequencer #(.MAX_WC(4096), .LINE_BITS(16)) dut (
        .mipi_clk(mipi_clk), .reset(reset), .stop(stop),
        .word_in(word_in), .word_valid(word_valid),
        .data_id(data_id), .word_count(word_count),
        .pix_data(pix_data), .pix_be(pix_be), .pix_valid(pix_valid),
        .frame_start(frame_start), .frame_end(frame_end),
        .line_start(line_start), .line_end(line_end),
        .frame_active(frame_active), .line_count(line_count),
        .ecc_err(ecc_err), .pkt_abort(pkt_abort), .stop_req(stop_req)
    );

    always #5 mipi_clk = ~mipi_clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Drive one word; returns on the falling edge after the sampling edge.
    task automatic send_word(input logic [31:0] w);
        @(negedge mipi_clk);
        word_in    = w;
        word_valid = 1'b1;
        @(negedge mipi_clk);
        word_valid = 1'b0;
    endtask

    task automatic gap();
        repeat (3) @(negedge mipi_clk);
    endtask

    task automatic link_to_header();
        @(negedge mipi_clk);
        stop = 1'b1;
        repeat (2) @(negedge mipi_clk);
        stop = 1'b0;
        repeat (2) @(negedge mipi_clk);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge mipi_clk);
        checks++; if ({frame_active, stop_req, pix_valid, ecc_err, pkt_abort} !== 5'b0)
            $display("[TB] FAIL reset_flags: got %b expected 00000", {frame_active, stop_req, pix_valid, ecc_err, pkt_abort});
        else passed++;
        checks++; if ({data_id, word_count, pix_be, line_count} !== 44'h0)
            $display("[TB] FAIL reset_regs: got %h expected 0", {data_id, word_count, pix_be, line_count});
        else passed++;
        @(negedge mipi_clk);
        reset = 1'b1;
    endtask

    task automatic test_frame_start();
        link_to_header();
        send_word(32'h0000_0000);
        checks++; if (frame_start !== 1'b1) $display("[TB] FAIL fs_strobe: got %b expected 1", frame_start); else passed++;
        checks++; if (frame_active !== 1'b1) $display("[TB] FAIL fs_active: got %b expected 1", frame_active); else passed++;
        checks++; if (stop_req !== 1'b1) $display("[TB] FAIL fs_stop_req: got %b expected 1", stop_req); else passed++;
        checks++; if (line_count !== 16'd0) $display("[TB] FAIL fs_line_count: got %0d expected 0", line_count); else passed++;
        @(negedge mipi_clk);
        checks++; if (frame_start !== 1'b0) $display("[TB] FAIL fs_one_cycle: got %b expected 0", frame_start); else passed++;
        checks++; if (stop_req !== 1'b1) $display("[TB] FAIL fs_stop_req_hold: got %b expected 1", stop_req); else passed++;
        stop = 1'b1;
        @(negedge mipi_clk);
        checks++; if (stop_req !== 1'b0) $display("[TB] FAIL fs_stop_req_clear: got %b expected 0", stop_req); else passed++;
    endtask

    task automatic test_line_start();
        link_to_header();
        send_word(32'h0B00_0002);
        checks++; if ({line_start, frame_start, pix_valid} !== 3'b100)
            $display("[TB] FAIL ls_strobes: got %b expected 100", {line_start, frame_start, pix_valid});
        else passed++;
        checks++; if (data_id !== 8'h02) $display("[TB] FAIL ls_data_id: got %h expected 02", data_id); else passed++;
    endtask

    task automatic test_raw8_wc6();
        link_to_header();
        send_word(32'h2F00_062A);
        checks++; if (data_id !== 8'h2A || word_count !== 16'd6)
            $display("[TB] FAIL wc6_header: got %h/%0d expected 2a/6", data_id, word_count);
        else passed++;
        checks++; if (stop_req !== 1'b0 || pix_valid !== 1'b0)
            $display("[TB] FAIL wc6_hdr_flags: got %b%b expected 00", stop_req, pix_valid);
        else passed++;
        gap();
        send_word(32'h4433_2211);
        checks++; if (pix_valid !== 1'b1 || pix_be !== 4'b1111 || pix_data !== 32'h4433_2211)
            $display("[TB] FAIL wc6_word1: got %b/%b/%h expected 1/1111/44332211", pix_valid, pix_be, pix_data);
        else passed++;
        gap();
        send_word(32'hAABB_6655);
        checks++; if (pix_valid !== 1'b1 || pix_be !== 4'b0011 || pix_data !== 32'hAABB_6655)
            $display("[TB] FAIL wc6_word2: got %b/%b/%h expected 1/0011/aabb6655", pix_valid, pix_be, pix_data);
        else passed++;
        checks++; if (stop_req !== 1'b1) $display("[TB] FAIL wc6_stop_req: got %b expected 1", stop_req); else passed++;
        checks++; if (line_count !== 16'd1) $display("[TB] FAIL wc6_line_count: got %0d expected 1", line_count); else passed++;
        gap();
        send_word(32'h1234_5678);
        checks++; if (pix_valid !== 1'b0) $display("[TB] FAIL wc6_ignored: got %b expected 0", pix_valid); else passed++;
    endtask

    task automatic test_wc8_footer();
        link_to_header();
        send_word(32'h3500_082A);
        checks++; if (word_count !== 16'd8) $display("[TB] FAIL wc8_header: got %0d expected 8", word_count); else passed++;
        gap();
        send_word(32'h0302_0100);
        checks++; if (pix_valid !== 1'b1 || pix_be !== 4'b1111)
            $display("[TB] FAIL wc8_word1: got %b/%b expected 1/1111", pix_valid, pix_be);
        else passed++;
        gap();
        send_word(32'h0706_0504);
        checks++; if (pix_valid !== 1'b1 || pix_be !== 4'b1111 || stop_req !== 1'b0)
            $display("[TB] FAIL wc8_word2: got %b/%b/%b expected 1/1111/0", pix_valid, pix_be, stop_req);
        else passed++;
        gap();
        send_word(32'hDEAD_BEEF);
        checks++; if (pix_valid !== 1'b0 || stop_req !== 1'b1 || pix_data !== 32'h0706_0504)
            $display("[TB] FAIL wc8_footer: got %b/%b/%h expected 0/1/07060504", pix_valid, stop_req, pix_data);
        else passed++;
        checks++; if (line_count !== 16'd2) $display("[TB] FAIL wc8_line_count: got %0d expected 2", line_count); else passed++;
    endtask

    task automatic test_bad_ecc();
        link_to_header();
        send_word(32'h2F00_0622);
        checks++; if (ecc_err !== 1'b1 || pix_valid !== 1'b0 || stop_req !== 1'b1)
            $display("[TB] FAIL ecc_flags: got %b%b%b expected 101", ecc_err, pix_valid, stop_req);
        else passed++;
        checks++; if (data_id !== 8'h2A || word_count !== 16'd8 || line_count !== 16'd2)
            $display("[TB] FAIL ecc_hold: got %h/%0d/%0d expected 2a/8/2", data_id, word_count, line_count);
        else passed++;
        @(negedge mipi_clk);
        checks++; if (ecc_err !== 1'b0) $display("[TB] FAIL ecc_one_cycle: got %b expected 0", ecc_err); else passed++;
    endtask

    task automatic test_wc_over_max();
        link_to_header();
        send_word(32'h3F20_002A);
        checks++; if (ecc_err !== 1'b1 || stop_req !== 1'b1 || word_count !== 16'h2000)
            $display("[TB] FAIL maxwc: got %b/%b/%h expected 1/1/2000", ecc_err, stop_req, word_count);
        else passed++;
        gap();
        send_word(32'h1111_1111);
        checks++; if (pix_valid !== 1'b0) $display("[TB] FAIL maxwc_no_payload: got %b expected 0", pix_valid); else passed++;
    endtask

    task automatic test_abort();
        link_to_header();
        send_word(32'h3600_102A);
        gap();
        send_word(32'hCAFE_F00D);
        checks++; if (pix_valid !== 1'b1 || pix_be !== 4'b1111)
            $display("[TB] FAIL abort_word1: got %b/%b expected 1/1111", pix_valid, pix_be);
        else passed++;
        stop = 1'b1;
        @(negedge mipi_clk);
        checks++; if (pkt_abort !== 1'b1 || stop_req !== 1'b0 || line_count !== 16'd2)
            $display("[TB] FAIL abort_pulse: got %b/%b/%0d expected 1/0/2", pkt_abort, stop_req, line_count);
        else passed++;
        @(negedge mipi_clk);
        checks++; if (pkt_abort !== 1'b0) $display("[TB] FAIL abort_one_cycle: got %b expected 0", pkt_abort); else passed++;
        stop = 1'b0;
        repeat (2) @(negedge mipi_clk);
        send_word(32'h0700_0001);
        checks++; if (frame_end !== 1'b1 || frame_active !== 1'b0 || stop_req !== 1'b1)
            $display("[TB] FAIL fe_after_abort: got %b/%b/%b expected 1/0/1", frame_end, frame_active, stop_req);
        else passed++;
    endtask

    task automatic test_reset_mid_packet();
        link_to_header();
        send_word(32'h0000_0000);
        link_to_header();
        send_word(32'h3600_102A);
        gap();
        send_word(32'h5555_AAAA);
        #2;
        reset = 1'b0;
        #1;
        checks++; if ({frame_active, pix_valid, pkt_abort, stop_req, ecc_err} !== 5'b0)
            $display("[TB] FAIL rst_mid_flags: got %b expected 00000", {frame_active, pix_valid, pkt_abort, stop_req, ecc_err});
        else passed++;
        checks++; if ({data_id, word_count, pix_data, pix_be, line_count} !== 76'h0)
            $display("[TB] FAIL rst_mid_regs: got %h expected 0", {data_id, word_count, pix_data, pix_be, line_count});
        else passed++;
        @(negedge mipi_clk);
        reset = 1'b1;
        link_to_header();
        send_word(32'h0000_0000);
        checks++; if (frame_start !== 1'b1 || frame_active !== 1'b1)
            $display("[TB] FAIL rst_recover: got %b/%b expected 1/1", frame_start, frame_active);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_frame_start();
        test_line_start();
        test_raw8_wc6();
        test_wc8_footer();
        test_bad_ecc();
        test_wc_over_max();
        test_abort();
        test_reset_mid_packet();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/csi_packet_sequencer.md
# csi_packet_sequencer

Packet-level controller for the two-lane CSI-2 receive path. Sits after the byte aligner in the `mipi_clk` domain and consumes its 32-bit aligned words. It checks the packet header ECC, classifies short and long packets, and sequences long-packet payload words out to the pixel path with byte enables. It tracks frame and line state and requests a return to stop state when a packet completes or is malformed.

## Interface
- `MAX_WC`, 4096: largest accepted long-packet word count, in bytes; a larger header WC is an error.
- `LINE_BITS`, 16: width of the line counter.
- `mipi_clk`  in  1  byte clock of the receive datapath; all logic is on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `stop`  in  1  high while the link is in LP/stop state; synchronous abort.
- `word_in`  in  32  aligned word, byte0 in bits [7:0].
- `word_valid`  in  1  one-cycle strobe marking a new `word_in`; at most one every 4 cycles.
- `data_id`  out  8  DI byte of the last accepted header.
- `word_count`  out  16  WC of the last accepted header.
- `pix_data`  out  32  payload word.
- `pix_be`  out  4  byte enables for `pix_data`.
- `pix_valid`  out  1  one-cycle strobe for a payload word.
- `frame_start`, `frame_end`, `line_start`, `line_end`  out  1 each  one-cycle strobes for DT 0x00, 0x01, 0x02 and 0x03 respectively.
- `frame_active`  out  1  high from frame start until frame end.
- `line_count`  out  LINE_BITS  long packets completed in the current frame.
- `ecc_err`  out  1  one-cycle strobe on a header ECC mismatch.
- `pkt_abort`  out  1  one-cycle strobe when `stop` truncates a long packet.
- `stop_req`  out  1  level; asks the SoT FSM to return to stop.

## Operation
- **States:** IDLE, HEADER, PAYLOAD, FOOTER, WAIT_STOP.
- **IDLE:** any `stop` low transitions to HEADER.
- **HEADER:** on the first `word_valid`, take DI = [7:0], WC = [23:8], ECC = [31:24].
  - Compute ECC as the CSI-2 6-bit Hamming code over [23:0], with bits 7:6 = 0.
  - Mismatch: pulse `ecc_err`, go to WAIT_STOP.
  - Match: latch `data_id` and `word_count`.
- **Short packet (DT < 0x10):**
  - Pulse the matching strobe, then go to WAIT_STOP.
  - DT 0x00 sets `frame_active` and clears `line_count`.
  - DT 0x01 clears `frame_active`.
  - DT 0x04–0x0F produce no strobe.
- **Long packet (DT ≥ 0x10):**
  - WC = 0 or WC > MAX_WC: go to WAIT_STOP and pulse `ecc_err`.
  - Otherwise load a down-counter `rem = WC` and go to PAYLOAD.
- **PAYLOAD:** each `word_valid` drives `pix_data = word_in` and pulses `pix_valid`.
  - `pix_be` = 4'b1111 while `rem ≥ 4`; otherwise it is the low `rem` bits set (rem = 1 → 0001, 2 → 0011, 3 → 0111).
  - Then `rem ← rem − min(rem, 4)`.
  - When rem reaches 0, the 2 CRC bytes follow. If `WC mod 4` is 0 or 3, one more word is needed, so go to FOOTER; otherwise the CRC was in the last word, so go to WAIT_STOP.
  - CRC is not checked.
- **FOOTER:** the next `word_valid` is discarded; go to WAIT_STOP.
- **End of long packet:** on entering WAIT_STOP from PAYLOAD or FOOTER, `line_count` increments, saturating at all-ones. It increments only while `frame_active`.
- **WAIT_STOP:** `stop_req` = 1, and `word_valid` is ignored. When `stop` = 1, go to IDLE and clear `stop_req`.
- **`stop` = 1 in HEADER, PAYLOAD or FOOTER:** go to IDLE next cycle.
  - Pulse `pkt_abort` if the state was PAYLOAD or FOOTER.
  - No `line_count` increment.
- **Simultaneous `stop` and `word_valid`:** `stop` wins, and the word is dropped.

## Timing
- All outputs are registered and update 1 cycle after the `word_valid` edge that causes them.
- `pix_valid` is never asserted in the same cycle as any framing strobe.
- **Reset values:** state IDLE; every strobe 0; `stop_req` 0; `frame_active` 0; `line_count` 0; `data_id`, `word_count`, `pix_data`, `pix_be` all 0.
- **Reset is asynchronous:**
  - Assertion mid-packet clears everything immediately, with no `pkt_abort`.
  - Deassertion takes effect on the next `mipi_clk` edge.
- `data_id` and `word_count` hold until the next valid header.

## Test plan
- **Frame start:** header 0x00 DT, WC 0x0000, correct ECC → `frame_start` pulse 1 cycle after `word_valid`, `frame_active` = 1, `line_count` = 0, `stop_req` = 1 until `stop`.
- **RAW8 long packet:** DT 0x2A, WC 6 → 2 payload words with `pix_be` 1111 then 0011, no FOOTER word consumed. With `frame_active` = 1, `line_count` goes 0 → 1.
- **WC = 8:** DT 0x2A, WC 8 → 2 words with `pix_be` 1111 and 1111, the third word is discarded (FOOTER), then `stop_req` = 1.
- **Bad ECC:** flip header bit 3 → `ecc_err` pulse, no `pix_valid`, `stop_req` = 1, `line_count` unchanged.
- **Abort:** `stop` = 1 after the first payload word of WC 16 → `pkt_abort` pulse, state IDLE, `line_count` unchanged. Then a frame-end header → `frame_end` pulse and `frame_active` = 0.
- **Reset mid-packet:** `reset` = 0 in PAYLOAD → all outputs at reset values in the same cycle; after release, a valid frame-start header is accepted normally.
